// File: rtl/pool2_stream_if.sv
// Row stream between the second conv stage and the 2x2 max-pool stage.
// Latency: none (wires only).
// Backpressure: none; the pool stage output has no ready, consumer must accept.
interface pool2_stream_if #(
   parameter int PIX_W = 8,
   parameter int ROW_W = 36
);
   logic                       clr_i;
   logic                       valid_i;
   logic [PIX_W*ROW_W-1:0]     data_i;
   logic                       valid_o;
   logic [PIX_W*ROW_W/2-1:0]   data_o;
   logic                       sof_o;
   logic                       eof_o;
   logic                       frame_done_o;

   // Producer side: drives rows in, observes pooled rows.
   modport master (
      output clr_i, valid_i, data_i,
      input  valid_o, data_o, sof_o, eof_o, frame_done_o
   );

   // Pool stage side.
   modport slave (
      input  clr_i, valid_i, data_i,
      output valid_o, data_o, sof_o, eof_o, frame_done_o
   );
endinterface

// File: rtl/pool2_stream.sv
// Streaming 2x2 max-pool: buffers even rows, pools against the following odd row, optional ReLU.
// Latency: pooled row appears 1 cycle after the odd-row beat; at most one output per 2 input beats.
// Backpressure: none; one row may arrive every cycle and every pooled row must be accepted.
module pool2_stream #(
   parameter int PIX_W = 8,
   parameter int ROW_W = 36,
   parameter int ROWS  = 32,
   parameter int RELU  = 1
) (
   input  logic          clk,
   input  logic          rst,
   pool2_stream_if.slave s_if
);
   localparam int OUT_W = ROW_W / 2;
   localparam int DW_I  = PIX_W * ROW_W;
   localparam int DW_O  = PIX_W * OUT_W;
   localparam int CNT_W = $clog2(ROWS);

   typedef enum logic {S_EVEN, S_ODD} state_t;

   state_t             r_state;
   state_t             w_state_eff;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_eff;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [DW_I-1:0]    r_buf;
   logic [DW_O-1:0]    r_data;
   logic [DW_O-1:0]    w_pool;
   logic               r_valid;
   logic               r_sof;
   logic               r_eof;
   logic               w_load;
   logic               w_emit;
   logic               w_sof;
   logic               w_eof;

   // Signed max of one 2x2 window, clamped at zero when ReLU is enabled.
   function automatic logic [PIX_W-1:0] pool4(
      input logic signed [PIX_W-1:0] a,
      input logic signed [PIX_W-1:0] b,
      input logic signed [PIX_W-1:0] c,
      input logic signed [PIX_W-1:0] d
   );
      logic signed [PIX_W-1:0] m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if ((RELU != 0) && (m < 0)) m = '0;
      return m;
   endfunction

   // Pool the buffered even row against the incoming odd row, pixel pair by pixel pair.
   always_comb begin
      w_pool = '0;
      for (int j = 0; j < OUT_W; j++) begin
         w_pool[PIX_W*j +: PIX_W] = pool4(r_buf[PIX_W*(2*j)   +: PIX_W],
                                          r_buf[PIX_W*(2*j+1) +: PIX_W],
                                          s_if.data_i[PIX_W*(2*j)   +: PIX_W],
                                          s_if.data_i[PIX_W*(2*j+1) +: PIX_W]);
      end
   end

   // Next state / counter / strobes; a clear acts before the beat of the same cycle.
   always_comb begin
      w_state_eff = s_if.clr_i ? S_EVEN : r_state;
      w_cnt_eff   = s_if.clr_i ? '0 : r_cnt;
      w_state_nxt = w_state_eff;
      w_cnt_nxt   = w_cnt_eff;
      w_load      = 1'b0;
      w_emit      = 1'b0;
      if (s_if.valid_i) begin
         w_cnt_nxt = (w_cnt_eff == CNT_W'(ROWS - 1)) ? '0 : w_cnt_eff + 1'b1;
         case (w_state_eff)
            S_EVEN: begin
               w_load      = 1'b1;
               w_state_nxt = S_ODD;
            end
            S_ODD: begin
               w_emit      = 1'b1;
               w_state_nxt = S_EVEN;
            end
            default: w_state_nxt = S_EVEN;
         endcase
      end
      // Pooled row index is the counter of the odd row divided by two.
      w_sof = w_emit && ((w_cnt_eff >> 1) == '0);
      w_eof = w_emit && (w_cnt_eff == CNT_W'(ROWS - 1));
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_EVEN;
      else     r_state <= w_state_nxt;
   end

   // Row counter and even-row line buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_buf <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_load) r_buf <= s_if.data_i;
      end
   end

   // Output register: strobes pulse for one cycle, data holds between pooled rows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_sof   <= 1'b0;
         r_eof   <= 1'b0;
         r_data  <= '0;
      end else begin
         r_valid <= w_emit;
         r_sof   <= w_sof;
         r_eof   <= w_eof;
         if (w_emit) r_data <= w_pool;
      end
   end

   assign s_if.valid_o      = r_valid;
   assign s_if.data_o       = r_data;
   assign s_if.sof_o        = r_sof;
   assign s_if.eof_o        = r_eof;
   assign s_if.frame_done_o = r_eof;
endmodule

// File: tb/tb_pool2_stream.sv
// Bench for pool2_stream: directed vector table plus streaming, abort and reset sequences.
// Latency: expects pooled row one cycle after the odd-row beat.
// Backpressure: none; every pooled row is captured by a monitor.
module tb_pool2_stream;
   localparam int PIX_W = 8;
   localparam int ROW_W = 36;
   localparam int ROWS  = 32;
   localparam int DW    = PIX_W * ROW_W;
   localparam int OW    = DW / 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   pool2_stream_if #(.PIX_W(PIX_W), .ROW_W(ROW_W)) u_if1 ();
   pool2_stream_if #(.PIX_W(PIX_W), .ROW_W(ROW_W)) u_if0 ();

   pool2_stream #(.PIX_W(PIX_W), .ROW_W(ROW_W), .ROWS(ROWS), .RELU(1)) dut1 (
      .clk(clk), .rst(rst), .s_if(u_if1.slave));
   pool2_stream #(.PIX_W(PIX_W), .ROW_W(ROW_W), .ROWS(ROWS), .RELU(0)) dut0 (
      .clk(clk), .rst(rst), .s_if(u_if0.slave));

   typedef struct {
      logic [7:0] b0, i0, b1, i1;
      logic [7:0] e1_first, e1_last, e0_first, e0_last;
   } vec_t;

   typedef struct {
      logic [OW-1:0] d;
      logic          sof, eof, fd;
      int            cyc;
   } obs_t;

   obs_t          obs_q[$];
   logic [OW-1:0] exp_q[$];
   bit            m_odd = 1'b0;
   int            m_cnt = 0;
   logic [DW-1:0] m_buf = '0;

   // Cycle counter for output spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Capture every pooled row of the ReLU instance.
   always @(negedge clk) begin
      if (!rst && u_if1.valid_o)
         obs_q.push_back('{u_if1.data_o, u_if1.sof_o, u_if1.eof_o, u_if1.frame_done_o, cyc});
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [DW-1:0] mkrow(input logic [7:0] b, input logic [7:0] inc);
      logic [DW-1:0] r;
      r = '0;
      for (int k = 0; k < ROW_W; k++) r[8*k +: 8] = b + 8'(k) * inc;
      return r;
   endfunction

   function automatic logic [OW-1:0] pool_ref(input logic [DW-1:0] b, input logic [DW-1:0] r,
                                              input bit relu);
      logic [OW-1:0] o;
      logic [7:0]    p;
      int            m;
      int            v;
      o = '0;
      for (int j = 0; j < ROW_W / 2; j++) begin
         m = -1000;
         for (int q = 0; q < 4; q++) begin
            case (q)
               0:       p = b[16*j +: 8];
               1:       p = b[16*j + 8 +: 8];
               2:       p = r[16*j +: 8];
               default: p = r[16*j + 8 +: 8];
            endcase
            v = int'($signed(p));
            if (v > m) m = v;
         end
         if (relu && m < 0) m = 0;
         o[8*j +: 8] = 8'(m);
      end
      return o;
   endfunction

   task automatic drive(input logic v, input logic c, input logic [DW-1:0] d);
      u_if1.valid_i = v; u_if1.clr_i = c; u_if1.data_i = d;
      u_if0.valid_i = v; u_if0.clr_i = c; u_if0.data_i = d;
   endtask

   task automatic beat(input logic [DW-1:0] d, input logic c);
      @(negedge clk);
      drive(1'b1, c, d);
      if (c) begin m_odd = 1'b0; m_cnt = 0; end
      if (!m_odd) begin
         m_buf = d;
         m_odd = 1'b1;
      end else begin
         exp_q.push_back(pool_ref(m_buf, d, 1'b1));
         m_odd = 1'b0;
      end
      m_cnt = (m_cnt + 1) % ROWS;
   endtask

   task automatic idle();
      @(negedge clk);
      drive(1'b0, 1'b0, '0);
   endtask

   task automatic clr_cycle();
      @(negedge clk);
      drive(1'b0, 1'b1, '0);
      m_odd = 1'b0;
      m_cnt = 0;
   endtask

   function automatic logic [DW-1:0] rnd_row();
      logic [DW-1:0] r;
      for (int w = 0; w < DW / 32; w++) r[32*w +: 32] = $urandom;
      return r;
   endfunction

   task automatic start_stream();
      clr_cycle();
      idle();
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_stream(input string tag, input int n_exp, input int sof_a, input int sof_b,
                               input int eof_a, input int eof_b, input bit spacing);
      chk({tag, "_count"}, DW'(obs_q.size()), DW'(n_exp));
      chk({tag, "_model_count"}, DW'(exp_q.size()), DW'(n_exp));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         chk($sformatf("%s_data%0d", tag, i), DW'(obs_q[i].d), DW'(exp_q[i]));
         chk($sformatf("%s_sof%0d", tag, i), DW'(obs_q[i].sof), DW'(i == sof_a || i == sof_b));
         chk($sformatf("%s_eof%0d", tag, i), DW'(obs_q[i].eof), DW'(i == eof_a || i == eof_b));
         chk($sformatf("%s_fd%0d", tag, i), DW'(obs_q[i].fd), DW'(i == eof_a || i == eof_b));
         if (spacing && i > 0)
            chk($sformatf("%s_gap%0d", tag, i), DW'(obs_q[i].cyc - obs_q[i-1].cyc), DW'(2));
      end
   endtask

   initial begin
      vec_t          vecs[5];
      logic [DW-1:0] r0, r1, row20;
      logic [OW-1:0] all20;

      vecs[0] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h24, 8'h02, 8'h24};
      vecs[1] = '{8'h80, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
      vecs[2] = '{8'hFF, 8'hFF, 8'hF0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hF0};
      vecs[3] = '{8'h7F, 8'h00, 8'h80, 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
      vecs[4] = '{8'h00, 8'h08, 8'h81, 8'h00, 8'h08, 8'h18, 8'h08, 8'h18};

      drive(1'b0, 1'b0, '0);
      repeat (2) @(negedge clk);
      chk("rst_valid", DW'(u_if1.valid_o), DW'(0));
      chk("rst_data", DW'(u_if1.data_o), DW'(0));
      chk("rst_sof", DW'(u_if1.sof_o), DW'(0));
      chk("rst_eof", DW'(u_if1.eof_o), DW'(0));
      chk("rst_fd", DW'(u_if1.frame_done_o), DW'(0));
      rst = 1'b0;

      // Directed single-pair vectors, each starting a fresh frame.
      for (int i = 0; i < 5; i++) begin
         r0 = mkrow(vecs[i].b0, vecs[i].i0);
         r1 = mkrow(vecs[i].b1, vecs[i].i1);
         clr_cycle();
         beat(r0, 1'b0);
         beat(r1, 1'b0);
         chk($sformatf("v%0d_no_early", i), DW'(u_if1.valid_o), DW'(0));
         idle();
         chk($sformatf("v%0d_valid", i), DW'(u_if1.valid_o), DW'(1));
         chk($sformatf("v%0d_sof", i), DW'(u_if1.sof_o), DW'(1));
         chk($sformatf("v%0d_eof", i), DW'(u_if1.eof_o), DW'(0));
         chk($sformatf("v%0d_r1_out0", i), DW'(u_if1.data_o[7:0]), DW'(vecs[i].e1_first));
         chk($sformatf("v%0d_r1_out17", i), DW'(u_if1.data_o[143:136]), DW'(vecs[i].e1_last));
         chk($sformatf("v%0d_r0_out0", i), DW'(u_if0.data_o[7:0]), DW'(vecs[i].e0_first));
         chk($sformatf("v%0d_r0_out17", i), DW'(u_if0.data_o[143:136]), DW'(vecs[i].e0_last));
         chk($sformatf("v%0d_r1_row", i), DW'(u_if1.data_o), DW'(pool_ref(r0, r1, 1'b1)));
         chk($sformatf("v%0d_r0_row", i), DW'(u_if0.data_o), DW'(pool_ref(r0, r1, 1'b0)));
         idle();
         chk($sformatf("v%0d_pulse", i), DW'(u_if1.valid_o), DW'(0));
         chk($sformatf("v%0d_hold", i), DW'(u_if1.data_o[143:136]), DW'(vecs[i].e1_last));
      end

      // One full frame back-to-back.
      start_stream();
      for (int i = 0; i < ROWS; i++) beat(rnd_row(), 1'b0);
      repeat (3) idle();
      check_stream("frame", 16, 0, -1, 15, -1, 1'b1);

      // Two frames with no gap.
      start_stream();
      for (int i = 0; i < 2 * ROWS; i++) beat(rnd_row(), 1'b0);
      repeat (3) idle();
      check_stream("wrap", 32, 0, 16, 15, 31, 1'b1);

      // Abort in ODD: clear with a row on the same cycle restarts the frame at that row.
      start_stream();
      for (int i = 0; i < 5; i++) beat(rnd_row(), 1'b0);
      beat(rnd_row(), 1'b1);
      for (int i = 0; i < ROWS - 1; i++) beat(rnd_row(), 1'b0);
      repeat (3) idle();
      check_stream("abort", 18, 0, 2, 17, -1, 1'b0);

      // Asynchronous reset while a row sits in the line buffer.
      clr_cycle();
      beat(mkrow(8'h33, 8'h00), 1'b0);
      beat(mkrow(8'h44, 8'h00), 1'b0);
      beat(mkrow(8'h55, 8'h00), 1'b0);
      chk("ar_pre_valid", DW'(u_if1.valid_o), DW'(1));
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", DW'(u_if1.valid_o), DW'(0));
      chk("ar_data", DW'(u_if1.data_o), DW'(0));
      chk("ar_sof", DW'(u_if1.sof_o), DW'(0));
      chk("ar_eof", DW'(u_if1.eof_o), DW'(0));
      chk("ar_fd", DW'(u_if1.frame_done_o), DW'(0));
      chk("ar_data_r0", DW'(u_if0.data_o), DW'(0));
      @(negedge clk);
      drive(1'b0, 1'b0, '0);
      rst   = 1'b0;
      m_odd = 1'b0;
      m_cnt = 0;
      beat(mkrow(8'h10, 8'h00), 1'b0);
      beat(mkrow(8'h20, 8'h00), 1'b0);
      idle();
      row20 = mkrow(8'h20, 8'h00);
      all20 = row20[OW-1:0];
      chk("ar_post_valid", DW'(u_if1.valid_o), DW'(1));
      chk("ar_post_data", DW'(u_if1.data_o), DW'(all20));
      chk("ar_post_sof", DW'(u_if1.sof_o), DW'(1));
      idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
